// File: rtl/mux_rca_pkg.sv
// Shared types and helpers for the mux-built pipelined ripple-carry adder.
// The optional overflow output is enabled in the top by MUX_RCA_OVERFLOW_EN.
package mux_rca_pkg;

    localparam int MUX_RCA_MAX_STAGES = 64;

    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctrl_t;

    function automatic int stage_chunk(input int width, input int num_stages);
        return width / num_stages;
    endfunction

    // The only logic primitive the adder is allowed to use.
    function automatic logic mux2(input logic sel, input logic d0, input logic d1);
        return sel ? d1 : d0;
    endfunction

endpackage

// File: rtl/mux_full_adder_slice.sv
// One-bit full adder built only from 2:1 mux slices.
// The carry is a 7-mux truth-table tree; the sum is a mux XOR chain.
module mux_full_adder_slice
    import mux_rca_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    logic m00, m01, m10, m11;
    logic n0, n1;
    logic b_n, c_n, p;

    // Carry tree: leaves are majority(a, b, c_in), selected by c_in, then b, then a.
    assign m00   = mux2(c_in, 1'b0, 1'b0);
    assign m01   = mux2(c_in, 1'b0, 1'b1);
    assign m10   = mux2(c_in, 1'b0, 1'b1);
    assign m11   = mux2(c_in, 1'b1, 1'b1);
    assign n0    = mux2(b, m00, m01);
    assign n1    = mux2(b, m10, m11);
    assign c_out = mux2(a, n0, n1);

    assign b_n = mux2(b, 1'b1, 1'b0);
    assign p   = mux2(a, b, b_n);
    assign c_n = mux2(c_in, 1'b1, 1'b0);
    assign s   = mux2(p, c_in, c_n);

endmodule

// File: rtl/mux_rca_pipe.sv
// Pipelined ripple-carry adder made of mux full-adder slices, valid/ready on both sides.
// Define MUX_RCA_OVERFLOW_EN to add a registered signed-overflow output aligned with sum.
module mux_rca_pipe
    import mux_rca_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NUM_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef MUX_RCA_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int C = stage_chunk(WIDTH, NUM_STAGES);

    if (NUM_STAGES < 1 || NUM_STAGES > WIDTH || NUM_STAGES > MUX_RCA_MAX_STAGES) begin : g_chk_stages
        $error("mux_rca_pipe: NUM_STAGES must be in 1..min(WIDTH, MUX_RCA_MAX_STAGES)");
    end
    if ((WIDTH % NUM_STAGES) != 0) begin : g_chk_width
        $error("mux_rca_pipe: WIDTH must be a multiple of NUM_STAGES");
    end

    logic stall;

    genvar k, i;
    for (k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam int LO   = k * C;
        localparam int REM  = WIDTH - LO;
        localparam int DONE = LO + C;

        // Operands shrink as they travel: stage k only carries the bits it and later stages still need.
        stage_ctrl_t     src_ctrl;
        logic [REM-1:0]  src_a;
        logic [REM-1:0]  src_b;
        logic [C:0]      chain;
        logic [C-1:0]    s_bits;
        logic [DONE-1:0] psum_nxt;
        stage_ctrl_t     ctrl_q, ctrl_d;
        logic [DONE-1:0] psum_q, psum_d;

        if (k == 0) begin : g_src
            assign src_ctrl = '{valid: in_valid, carry: c_in};
            assign src_a    = a;
            assign src_b    = b;
            assign psum_nxt = s_bits;
        end else begin : g_src
            assign src_ctrl = g_stage[k-1].ctrl_q;
            assign src_a    = g_stage[k-1].g_fwd.opa_q;
            assign src_b    = g_stage[k-1].g_fwd.opb_q;
            assign psum_nxt = {s_bits, g_stage[k-1].psum_q};
        end

        assign chain[0] = src_ctrl.carry;
        for (i = 0; i < C; i++) begin : g_bit
            mux_full_adder_slice u_fa (
                .a     (src_a[i]),
                .b     (src_b[i]),
                .c_in  (chain[i]),
                .s     (s_bits[i]),
                .c_out (chain[i+1])
            );
        end

        always_comb begin
            ctrl_d = ctrl_q;
            psum_d = psum_q;
            if (!stall) begin
                ctrl_d = '{valid: src_ctrl.valid, carry: chain[C]};
                psum_d = psum_nxt;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                ctrl_q <= '0;
                psum_q <= '0;
            end else begin
                ctrl_q <= ctrl_d;
                psum_q <= psum_d;
            end
        end

        if (k < NUM_STAGES - 1) begin : g_fwd
            logic [REM-C-1:0] opa_q, opa_d;
            logic [REM-C-1:0] opb_q, opb_d;

            always_comb begin
                opa_d = opa_q;
                opb_d = opb_q;
                if (!stall) begin
                    opa_d = src_a[REM-1:C];
                    opb_d = src_b[REM-1:C];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else begin
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                end
            end
        end

`ifdef MUX_RCA_OVERFLOW_EN
        if (k == NUM_STAGES - 1) begin : g_ovf
            logic ovf_q, ovf_d;

            always_comb begin
                ovf_d = ovf_q;
                if (!stall) ovf_d = chain[C] ^ chain[C-1];
            end

            always_ff @(posedge clk) begin
                if (rst) ovf_q <= 1'b0;
                else     ovf_q <= ovf_d;
            end

            assign overflow = ovf_q;
        end
`endif
    end

    // Gating with rst guarantees no output transfer in a reset cycle.
    assign out_valid = g_stage[NUM_STAGES-1].ctrl_q.valid && !rst;
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !rst && !stall;
    assign sum       = g_stage[NUM_STAGES-1].psum_q;
    assign c_out     = g_stage[NUM_STAGES-1].ctrl_q.carry;

endmodule

// File: doc/mux_rca_pipe.md
Name: mux_rca_pipe

Overview:
- Parametrised, pipelined ripple-carry adder built entirely from 2:1 mux slices.
- Computes sum = a + b + c_in over WIDTH bits. The adder is split into NUM_STAGES equal chunks, with the carry and partial sums registered between chunks.
- Valid/ready handshake on both sides, with full backpressure. Successor to the single-bit mux carry-out cell; used as the datapath adder in the mux-logic ALU.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be a multiple of NUM_STAGES.
- NUM_STAGES, 2, number of pipeline stages (1..WIDTH); each stage adds WIDTH/NUM_STAGES bits.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b, c_in are valid this cycle.
- in_ready  output  1  adder accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry in.
- out_valid  output  1  sum and c_out are valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  (a + b + c_in) mod 2^WIDTH.
- c_out  output  1  carry out of the MSB.

Behaviour:
- Reset:
  - rst is synchronous and active-high.
  - Every stage valid bit clears to 0, so out_valid = 0.
  - sum = 0, c_out = 0, and all pipeline data registers clear to 0.
  - in_ready = 1 in the cycle after reset is released. During reset, in_ready = 0.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_valid, a, b and c_in must be held until accepted; the same applies to out_valid, sum and c_out.
- Pipeline:
  - Stage k adds bit slice [k*C +: C], with C = WIDTH/NUM_STAGES.
  - The slice is built as a ripple of C full-adder slices. The carry-in of stage k is the registered carry from stage k-1; stage 0 uses c_in.
  - Upper operand bits and the already-computed lower sum bits travel alongside in registers.
- Latency:
  - Exactly NUM_STAGES cycles from input acceptance to out_valid when there is no stall.
  - Throughput is 1 result per cycle while out_ready = 1.
- Stall rule:
  - stall = out_valid && !out_ready.
  - While stalled, all stage registers hold and in_ready = 0.
  - Otherwise every stage advances by one and in_ready = 1; bubbles propagate as valid = 0.
  - No bubble compression is required.
- Simultaneous events:
  - Input accept and output accept in the same cycle are both legal; the pipeline advances normally.
- Reset mid-operation: all in-flight results are discarded, with no output transfer on the reset cycle.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH, with c_out = bit WIDTH of the full sum.
  - Boundary: a = b = all-ones, c_in = 1 gives sum = all-ones, c_out = 1.
- NUM_STAGES = 1: single registered stage, latency 1.
- NUM_STAGES = WIDTH: one bit per stage, latency WIDTH.

Optional Feature:
- Macro: MUX_RCA_OVERFLOW_EN.
- Defined:
  - Extra output port: overflow, output, 1 bit.
  - overflow is the signed two's-complement overflow, i.e. carry into MSB XOR carry out of MSB.
  - It is registered and aligned with sum; reset value 0.
- Undefined: the port does not exist and no overflow logic is generated.

Decomposition:
- Package mux_rca_pkg holds:
  - function stage_chunk(WIDTH, NUM_STAGES) returning the bits per stage.
  - typedef stage_ctrl_t: struct {valid, carry}.
  - localparam MUX_RCA_MAX_STAGES = 64.
- Sub-module mux_full_adder_slice (inputs a, b, c_in; outputs s, c_out):
  - Built only from 2:1 mux slices, 7 muxes for the carry and the sum via a mux XOR tree.
  - Instantiated C times per stage via generate.
- Elaboration-time assertion: WIDTH % NUM_STAGES == 0.

Test Plan (WIDTH=8, NUM_STAGES=2 unless stated):
- Reset, then a single op: a=8'h0F, b=8'h01, c_in=0 -> out_valid rises exactly 2 cycles after acceptance; sum=8'h10, c_out=0.
- Full carry ripple across the stage boundary: a=8'hFF, b=8'h00, c_in=1 -> sum=8'h00, c_out=1; with MUX_RCA_OVERFLOW_EN, overflow=0. Then a=8'h7F, b=8'h01 -> sum=8'h80, overflow=1.
- Back-to-back stream of 16 random ops, out_ready=1 -> 16 results in order, one per cycle after a 2-cycle latency, each matching a reference model.
- Backpressure: out_ready=0 for 5 cycles while results are pending -> in_ready=0 and sum held stable. After release, no result is lost or duplicated and order is preserved.
- Reset asserted with 2 results in flight -> the next cycle has out_valid=0 and sum=0. The first new op after release returns in 2 cycles with the correct value.
- Parameter sweep: WIDTH=8 with NUM_STAGES=1 and 8, plus WIDTH=16 with NUM_STAGES=4; an exhaustive or random sweep matches a+b+c_in with latency equal to NUM_STAGES.
